// File: rtl/result_bus_arbiter_pkg.sv
// Shared definitions for the result-bus arbiter: widths, source codes,
// output stage state encoding and the modulo-5 pointer helper.
package result_bus_arbiter_pkg;

    localparam int RESULT_W       = 32;
    localparam int NUM_RESULT_SRC = 5;

    localparam logic [2:0] SRC_ALU   = 3'd0;
    localparam logic [2:0] SRC_SHIFT = 3'd1;
    localparam logic [2:0] SRC_MUL   = 3'd2;
    localparam logic [2:0] SRC_MEM   = 3'd3;
    localparam logic [2:0] SRC_LINK  = 3'd4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // (base + step) mod 5 for base in 0..4 and step in 0..5.
    function automatic logic [2:0] rr_wrap(input logic [2:0] base, input logic [2:0] step);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 4'd5) begin
            sum = sum - 4'd5;
        end
        return sum[2:0];
    endfunction

endpackage

// File: rtl/result_bus_arbiter_rr_pick5.sv
// Combinational round-robin picker over five requesters: returns the first
// valid index after ptr (wrapping 4 -> 0) and whether any request exists.
module rr_pick5
    import result_bus_arbiter_pkg::*;
(
    input  logic [4:0] valid,
    input  logic [2:0] ptr,
    output logic [2:0] idx,
    output logic       any_valid
);

    logic       found;
    logic [2:0] cand;

    always_comb begin
        idx   = SRC_ALU;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= 5; k++) begin
            cand = rr_wrap(ptr, 3'(k));
            if (!found && valid[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter with bounded burst locking for the shared result bus,
// driving the result mux select and a one-deep valid/ready output register.
module result_bus_arbiter
    import result_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = NUM_RESULT_SRC,
    parameter int DATA_W   = RESULT_W,
    parameter int MAX_LOCK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [NUM_REQ-1:0]  req_lock,
    output logic [NUM_REQ-1:0]  req_ready,
    output logic [2:0]          mux_sel,
    input  logic [DATA_W-1:0]   mux_in,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [2:0]          out_src,
    input  logic                out_ready
);

    localparam logic [2:0] LOCK_LIMIT = 3'(MAX_LOCK);

    out_state_e  state;
    logic [2:0]  ptr;
    logic [2:0]  last;
    logic        lock_active;
    logic [2:0]  lock_cnt;

    logic [2:0]  rr_idx;
    logic        any_req;
    logic        lock_hold;
    logic [2:0]  winner;
    logic        load;

    rr_pick5 u_pick (
        .valid     (req_valid),
        .ptr       (ptr),
        .idx       (rr_idx),
        .any_valid (any_req)
    );

    // An expired lock falls back to round-robin from ptr+1, so the former
    // holder only wins again if nobody else is asking.
    assign lock_hold = lock_active && req_valid[last] && req_lock[last]
                       && (lock_cnt < LOCK_LIMIT);
    assign winner    = lock_hold ? last : rr_idx;
    assign mux_sel   = any_req ? winner : SRC_ALU;
    assign load      = any_req && ((state == ST_EMPTY) || out_ready);
    assign out_valid = (state == ST_FULL);

    always_comb begin
        req_ready = '0;
        if (load) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            out_data    <= '0;
            out_src     <= SRC_ALU;
            ptr         <= SRC_LINK;
            last        <= SRC_ALU;
            lock_active <= 1'b0;
            lock_cnt    <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (load) state <= ST_FULL;
                ST_FULL:  if (!load && out_ready) state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase

            if (load) begin
                out_data    <= mux_in;
                out_src     <= winner;
                ptr         <= winner;
                last        <= winner;
                lock_active <= req_lock[winner];
                // Saturating count; once at the limit the lock is ignored anyway.
                if ((winner == last) && lock_active) begin
                    if (lock_cnt < LOCK_LIMIT) begin
                        lock_cnt <= lock_cnt + 3'd1;
                    end
                end else begin
                    lock_cnt <= 3'd1;
                end
            end else if (!req_valid[last]) begin
                lock_active <= 1'b0;
            end
        end
    end

endmodule
